// File: rtl/damage_tracker.sv
// Per-fighter damage tracker: turns a level contact flag into discrete hits, tracks health,
// times a frame-counted invulnerability window and latches death until restart.
module damage_tracker #(
    parameter int HW            = 4,
    parameter int MAX_HEALTH    = 10,
    parameter int DAMAGE        = 1,
    parameter int INVULN_FRAMES = 30
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          frame_clk,
    input  logic          restart,
    input  logic          contact,
    output logic [HW-1:0] health,
    output logic          is_dead,
    output logic          hit,
    output logic          invuln,
    output logic          flash
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [HW-1:0] MAX_H  = HW'(MAX_HEALTH);
    localparam logic [HW-1:0] DMG    = HW'(DAMAGE);
    localparam logic [7:0]    INV_F  = 8'(INVULN_FRAMES);
    localparam logic [HW-1:0] ZERO_H = {HW{1'b0}};

    state_t        state_r;
    state_t        state_nx_s;
    logic          fsync1_r;
    logic          fsync2_r;
    logic          fsync3_r;
    logic          frame_tick_r;
    logic          contact_q_r;
    logic          contact_q_nx_s;
    logic          contact_rise_s;
    logic [7:0]    frame_cnt_r;
    logic [7:0]    frame_cnt_nx_s;
    logic [HW-1:0] health_r;
    logic [HW-1:0] health_nx_s;
    logic [HW-1:0] dmg_health_s;
    logic          hit_r;
    logic          hit_nx_s;
    logic          is_dead_r;
    logic          invuln_r;
    logic          flash_r;

    assign contact_rise_s = contact & ~contact_q_r;
    // Saturating subtract so a large DAMAGE can never wrap health upward.
    assign dmg_health_s   = (health_r <= DMG) ? ZERO_H : (health_r - DMG);

    // Synchronise the vertical-sync input and register its rising edge as a one-cycle tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsync1_r     <= 1'b0;
            fsync2_r     <= 1'b0;
            fsync3_r     <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            fsync1_r     <= frame_clk;
            fsync2_r     <= fsync1_r;
            fsync3_r     <= fsync2_r;
            frame_tick_r <= fsync2_r & ~fsync3_r;
        end
    end

    // Next-state, health, window counter and hit decision.
    always_comb begin
        state_nx_s     = state_r;
        health_nx_s    = health_r;
        frame_cnt_nx_s = frame_cnt_r;
        hit_nx_s       = 1'b0;
        contact_q_nx_s = contact;
        if (restart) begin
            state_nx_s     = ST_ALIVE;
            health_nx_s    = MAX_H;
            frame_cnt_nx_s = 8'd0;
            contact_q_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_ALIVE: begin
                    if (contact_rise_s) begin
                        hit_nx_s    = 1'b1;
                        health_nx_s = dmg_health_s;
                        if (dmg_health_s == ZERO_H) begin
                            state_nx_s = ST_DEAD;
                        end else if (INV_F == 8'd0) begin
                            state_nx_s = ST_ALIVE;
                        end else begin
                            state_nx_s     = ST_INVULN;
                            frame_cnt_nx_s = INV_F;
                        end
                    end else begin
                        state_nx_s = ST_ALIVE;
                    end
                end
                ST_INVULN: begin
                    if (frame_tick_r) begin
                        if (frame_cnt_r <= 8'd1) begin
                            // Clearing the edge history lets a still-held contact register as a new hit.
                            state_nx_s     = ST_ALIVE;
                            frame_cnt_nx_s = 8'd0;
                            contact_q_nx_s = 1'b0;
                        end else begin
                            frame_cnt_nx_s = frame_cnt_r - 8'd1;
                        end
                    end else begin
                        frame_cnt_nx_s = frame_cnt_r;
                    end
                end
                ST_DEAD: begin
                    health_nx_s = ZERO_H;
                end
                default: begin
                    state_nx_s     = ST_ALIVE;
                    health_nx_s    = MAX_H;
                    frame_cnt_nx_s = 8'd0;
                end
            endcase
        end
    end

    // State register plus registered copies of every output.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= ST_ALIVE;
            health_r    <= MAX_H;
            frame_cnt_r <= 8'd0;
            contact_q_r <= 1'b0;
            hit_r       <= 1'b0;
            is_dead_r   <= 1'b0;
            invuln_r    <= 1'b0;
            flash_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            health_r    <= health_nx_s;
            frame_cnt_r <= frame_cnt_nx_s;
            contact_q_r <= contact_q_nx_s;
            hit_r       <= hit_nx_s;
            is_dead_r   <= (state_nx_s == ST_DEAD);
            invuln_r    <= (state_nx_s == ST_INVULN);
            flash_r     <= (state_nx_s == ST_INVULN) & frame_cnt_nx_s[2];
        end
    end

    assign health  = health_r;
    assign is_dead = is_dead_r;
    assign hit     = hit_r;
    assign invuln  = invuln_r;
    assign flash   = flash_r;

endmodule

// File: tb/tb_damage_tracker.sv
// Directed bench for damage_tracker: default instance plus a DAMAGE=3, no-invulnerability instance.
module tb_damage_tracker;

    logic       Clk       = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       frame_clk = 1'b0;
    logic       restart   = 1'b0;
    logic       contact   = 1'b0;
    logic       contact3  = 1'b0;
    logic [3:0] health;
    logic [3:0] health3;
    logic       is_dead, hit, invuln, flash;
    logic       is_dead3, hit3, invuln3, flash3;
    int         checks   = 0;
    int         failures = 0;

    damage_tracker #(.HW(4), .MAX_HEALTH(10), .DAMAGE(1), .INVULN_FRAMES(30)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
        .contact(contact), .health(health), .is_dead(is_dead), .hit(hit),
        .invuln(invuln), .flash(flash)
    );

    damage_tracker #(.HW(4), .MAX_HEALTH(10), .DAMAGE(3), .INVULN_FRAMES(0)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
        .contact(contact3), .health(health3), .is_dead(is_dead3), .hit(hit3),
        .invuln(invuln3), .flash(flash3)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full frame pulses (4 cycles high, 4 low); counts hit cycles seen on the default instance.
    task automatic run_frames(input int n, output int hits_seen);
        hits_seen = 0;
        for (int f = 0; f < n; f++) begin
            frame_clk = 1'b1;
            repeat (4) begin @(negedge Clk); hits_seen += int'(hit); end
            frame_clk = 1'b0;
            repeat (4) begin @(negedge Clk); hits_seen += int'(hit); end
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int         hs;
        int         exp6[4];
        logic [7:0] jit;
        exp6 = '{7, 4, 1, 0};
        jit  = 8'b1011_0010;

        // 1. reset
        repeat (2) @(negedge Clk);
        check("rst_health", 32'(health), 32'd10);
        check("rst_dead",   32'(is_dead), 32'd0);
        check("rst_invuln", 32'(invuln), 32'd0);
        check("rst_hit",    32'(hit), 32'd0);
        check("rst_flash",  32'(flash), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rel_health",  32'(health), 32'd10);
        check("rel_health3", 32'(health3), 32'd10);

        // 2. single hit, 30-tick window, flash pattern
        contact = 1'b1;
        @(negedge Clk);
        contact = 1'b0;
        check("t2_hit",    32'(hit), 32'd1);
        check("t2_health", 32'(health), 32'd9);
        check("t2_invuln", 32'(invuln), 32'd1);
        check("t2_flash0", 32'(flash), 32'd1);
        @(negedge Clk);
        check("t2_hit_off", 32'(hit), 32'd0);
        for (int k = 1; k <= 30; k++) begin
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            check($sformatf("t2_invuln_k%0d", k), 32'(invuln), (k < 30) ? 32'd1 : 32'd0);
            check($sformatf("t2_flash_k%0d", k), 32'(flash),
                  (k < 30) ? 32'(((30 - k) >> 2) & 1) : 32'd0);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
        check("t2_health_end", 32'(health), 32'd9);

        // 3. contact held through the window
        do_restart();
        check("rs_health", 32'(health), 32'd10);
        check("rs_invuln", 32'(invuln), 32'd0);
        contact = 1'b1;
        @(negedge Clk);
        check("t3_hit1",    32'(hit), 32'd1);
        check("t3_health1", 32'(health), 32'd9);
        run_frames(29, hs);
        check("t3_nohit_window", 32'(hs), 32'd0);
        check("t3_invuln_29", 32'(invuln), 32'd1);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        check("t3_invuln_drop", 32'(invuln), 32'd0);
        check("t3_hit_at_drop", 32'(hit), 32'd0);
        check("t3_health_drop", 32'(health), 32'd9);
        @(negedge Clk);
        check("t3_hit2",    32'(hit), 32'd1);
        check("t3_health2", 32'(health), 32'd8);
        check("t3_reinv",   32'(invuln), 32'd1);
        contact   = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk);
        check("t3_hit2_off", 32'(hit), 32'd0);
        repeat (3) @(negedge Clk);

        // 4. ten hits to death, then contact ignored
        do_restart();
        for (int i = 1; i <= 10; i++) begin
            contact = 1'b1;
            @(negedge Clk);
            contact = 1'b0;
            check($sformatf("t4_hit_%0d", i), 32'(hit), 32'd1);
            check($sformatf("t4_health_%0d", i), 32'(health), 32'(10 - i));
            check($sformatf("t4_dead_%0d", i), 32'(is_dead), (i == 10) ? 32'd1 : 32'd0);
            check($sformatf("t4_invuln_%0d", i), 32'(invuln), (i < 10) ? 32'd1 : 32'd0);
            @(negedge Clk);
            check($sformatf("t4_hit_off_%0d", i), 32'(hit), 32'd0);
            if (i < 10) begin
                run_frames(30, hs);
            end
        end
        for (int j = 0; j < 3; j++) begin
            contact = 1'b1;
            @(negedge Clk);
            contact = 1'b0;
            check($sformatf("t4_dead_hit_%0d", j), 32'(hit), 32'd0);
            check($sformatf("t4_dead_health_%0d", j), 32'(health), 32'd0);
            @(negedge Clk);
        end
        run_frames(2, hs);
        check("t4_dead_frames_hits", 32'(hs), 32'd0);
        check("t4_dead_hold", 32'(is_dead), 32'd1);

        // 5. restart coincident with a contact edge at health 5
        do_restart();
        check("t5_restart_dead", 32'(is_dead), 32'd0);
        for (int i = 0; i < 5; i++) begin
            contact = 1'b1;
            @(negedge Clk);
            contact = 1'b0;
            @(negedge Clk);
            run_frames(30, hs);
        end
        check("t5_health5", 32'(health), 32'd5);
        check("t5_alive5",  32'(invuln), 32'd0);
        contact = 1'b1;
        restart = 1'b1;
        @(negedge Clk);
        check("t5_health", 32'(health), 32'd10);
        check("t5_hit",    32'(hit), 32'd0);
        check("t5_invuln", 32'(invuln), 32'd0);
        check("t5_dead",   32'(is_dead), 32'd0);
        contact = 1'b0;
        restart = 1'b0;
        @(negedge Clk);
        check("t5_hit_after", 32'(hit), 32'd0);
        contact = 1'b1;
        @(negedge Clk);
        contact = 1'b0;
        check("t5_alive_hit",    32'(hit), 32'd1);
        check("t5_alive_health", 32'(health), 32'd9);

        // 6. DAMAGE=3, no invulnerability, saturation, frame jitter
        @(negedge Clk);
        check("t6_start", 32'(health3), 32'd10);
        for (int i = 0; i < 4; i++) begin
            contact3 = 1'b1;
            @(negedge Clk);
            check($sformatf("t6_hit_%0d", i), 32'(hit3), 32'd1);
            check($sformatf("t6_health_%0d", i), 32'(health3), 32'(exp6[i]));
            check($sformatf("t6_dead_%0d", i), 32'(is_dead3), (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("t6_invuln_%0d", i), 32'(invuln3), 32'd0);
            @(negedge Clk);
            check($sformatf("t6_held_nohit_%0d", i), 32'(hit3), 32'd0);
            contact3 = 1'b0;
            for (int j = 0; j < 8; j++) begin
                frame_clk = jit[j];
                @(negedge Clk);
            end
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
            check($sformatf("t6_jitter_health_%0d", i), 32'(health3), 32'(exp6[i]));
        end
        contact3 = 1'b1;
        @(negedge Clk);
        contact3 = 1'b0;
        check("t6_dead_nohit",  32'(hit3), 32'd0);
        check("t6_dead_health", 32'(health3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
